// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory, fills the IF/ID register, and resolves J in place
// so a jump costs no bubble. Later stages may stall or redirect it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      inst_addr,
  input  logic [31:0]      inst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_target,
  output logic             ifid_valid,
  output logic [31:0]      ifid_inst,
  output logic [31:0]      ifid_pc4,
  output logic             addr_err,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [5:0]       OP_J    = 6'b000010;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A fetch target must be word aligned; any low-order bit set is an error.
  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  logic [31:0]      pc_r;
  logic [31:0]      pc4_s;
  logic             is_jump_s;
  logic [31:0]      jump_target_s;

  logic [31:0]      pc_nxt_s;
  logic             valid_nxt_s;
  logic [31:0]      inst_nxt_s;
  logic [31:0]      pc4_nxt_s;
  logic             err_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;

  assign inst_addr     = pc_r;
  assign pc4_s         = pc_r + 32'd4;
  assign is_jump_s     = (inst[31:26] == OP_J);
  assign jump_target_s = {pc4_s[31:28], inst[25:0], 2'b00};

  // Next-state selection: redirect beats stall, stall beats a normal fetch.
  always_comb begin
    pc_nxt_s    = pc_r;
    valid_nxt_s = ifid_valid;
    inst_nxt_s  = ifid_inst;
    pc4_nxt_s   = ifid_pc4;
    err_nxt_s   = addr_err;
    cnt_nxt_s   = fetch_cnt;
    if (redirect) begin
      // Flush IF/ID; the low address bits are dropped but remembered as an error.
      pc_nxt_s    = redirect_target & ~32'h0000_0003;
      valid_nxt_s = 1'b0;
      inst_nxt_s  = 32'h0000_0000;
      pc4_nxt_s   = 32'h0000_0000;
      err_nxt_s   = addr_err | misaligned(redirect_target);
    end else if (stall) begin
      // Hold everything; a J sitting in the fetch slot is not decoded yet.
      pc_nxt_s = pc_r;
    end else begin
      valid_nxt_s = 1'b1;
      inst_nxt_s  = inst;
      pc4_nxt_s   = pc4_s;
      cnt_nxt_s   = fetch_cnt + CNT_ONE;
      if (is_jump_s) begin
        pc_nxt_s = jump_target_s;
      end else begin
        pc_nxt_s = pc4_s;
      end
    end
  end

  // State registers with synchronous reset that overrides all other inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      ifid_valid <= 1'b0;
      ifid_inst  <= 32'h0000_0000;
      ifid_pc4   <= 32'h0000_0000;
      addr_err   <= 1'b0;
      fetch_cnt  <= {CNT_W{1'b0}};
    end else begin
      pc_r       <= pc_nxt_s;
      ifid_valid <= valid_nxt_s;
      ifid_inst  <= inst_nxt_s;
      ifid_pc4   <= pc4_nxt_s;
      addr_err   <= err_nxt_s;
      fetch_cnt  <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run compared against a rule-level reference model of the fetch stage.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc4;
  logic        addr_err;
  logic [31:0] fetch_cnt;

  int vectors;
  int miscompares;

  // reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_err;
  logic [31:0] m_cnt;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst(inst),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .ifid_valid(ifid_valid), .ifid_inst(ifid_inst), .ifid_pc4(ifid_pc4),
    .addr_err(addr_err), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the reference model, sample #1 after the edge.
  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [31:0] tgt, input logic [31:0] ins);
    logic [31:0] seq;
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_target = tgt; inst = ins;
    @(posedge clk);
    seq = m_pc + 32'd4;
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_inst = 32'h0; m_pc4 = 32'h0;
      m_err = 1'b0; m_cnt = 32'h0;
    end else if (rd) begin
      m_pc = tgt - (tgt % 32'd4);
      m_valid = 1'b0; m_inst = 32'h0; m_pc4 = 32'h0;
      if ((tgt % 32'd4) != 32'd0) m_err = 1'b1;
    end else if (!s) begin
      m_inst = ins; m_pc4 = seq; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      if ((ins >> 26) == 32'd2)
        m_pc = (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      else
        m_pc = seq;
    end
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if ({inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: pc=%h v=%b inst=%h pc4=%h err=%b cnt=%0d, expected all zero",
               inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h8C01_0001);
    vectors++;
    if ({ifid_inst, ifid_pc4, ifid_valid, inst_addr, fetch_cnt} !== {32'h8C01_0001, 32'h4, 1'b1, 32'h4, 32'd1}) begin
      miscompares++;
      $display("FAIL first_fetch: inst=%h pc4=%h v=%b pc=%h cnt=%0d, expected 8c010001 4 1 4 1",
               ifid_inst, ifid_pc4, ifid_valid, inst_addr, fetch_cnt);
    end
  endtask

  task automatic test_jump;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (inst_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL seq_pc: got %h expected 00000010", inst_addr);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0800_0006);
    vectors++;
    if ({inst_addr, ifid_inst, ifid_pc4, ifid_valid} !== {32'h18, 32'h0800_0006, 32'h14, 1'b1}) begin
      miscompares++;
      $display("FAIL jump: pc=%h inst=%h pc4=%h v=%b, expected 18 08000006 14 1",
               inst_addr, ifid_inst, ifid_pc4, ifid_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h2002_0005);
    vectors++;
    if ({inst_addr, ifid_inst, ifid_pc4, ifid_valid} !== {32'h1C, 32'h2002_0005, 32'h1C, 1'b1}) begin
      miscompares++;
      $display("FAIL jump_no_bubble: pc=%h inst=%h pc4=%h v=%b, expected 1c 20020005 1c 1",
               inst_addr, ifid_inst, ifid_pc4, ifid_valid);
    end
  endtask

  task automatic test_stall;
    logic [31:0] cnt0;
    drive(1'b0, 1'b0, 1'b1, 32'h4, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_1234);
    cnt0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      // J in the fetch slot must not be decoded while stalled
      drive(1'b0, 1'b1, 1'b0, 32'h0, (i == 1) ? 32'h0800_0040 : $urandom);
      vectors++;
      if ({inst_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_cnt} !== {32'h8, 32'h0000_1234, 32'h8, 1'b1, cnt0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: pc=%h inst=%h pc4=%h v=%b cnt=%0d, expected 8 00001234 8 1 %0d",
                 i, inst_addr, ifid_inst, ifid_pc4, ifid_valid, fetch_cnt, cnt0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hAAAA_0000);
    vectors++;
    if ({inst_addr, ifid_inst, ifid_pc4, fetch_cnt} !== {32'hC, 32'hAAAA_0000, 32'hC, cnt0 + 32'd1}) begin
      miscompares++;
      $display("FAIL stall_resume: pc=%h inst=%h pc4=%h cnt=%0d, expected c aaaa0000 c %0d",
               inst_addr, ifid_inst, ifid_pc4, fetch_cnt, cnt0 + 32'd1);
    end
  endtask

  task automatic test_redirect_stall;
    logic [31:0] cnt0;
    cnt0 = m_cnt;
    drive(1'b0, 1'b1, 1'b1, 32'h1C, 32'h0800_0001);
    vectors++;
    if ({inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt} !== {32'h1C, 1'b0, 32'h0, 32'h0, 1'b0, cnt0}) begin
      miscompares++;
      $display("FAIL redirect_over_stall: pc=%h v=%b inst=%h pc4=%h err=%b cnt=%0d, expected 1c 0 0 0 0 %0d",
               inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt, cnt0);
    end
  endtask

  task automatic test_addr_err;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0022, 32'h0);
    vectors++;
    if ({inst_addr, addr_err} !== {32'h20, 1'b1}) begin
      miscompares++;
      $display("FAIL misaligned_redirect: pc=%h err=%b, expected 20 1", inst_addr, addr_err);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, ($urandom % 3) == 0, ($urandom % 4) == 0, $urandom & 32'hFFFF_FFFC, $urandom);
    end
    vectors++;
    if (addr_err !== 1'b1) begin
      miscompares++;
      $display("FAIL addr_err_sticky: got %b expected 1", addr_err);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (addr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_err_clear: got %b expected 0", addr_err);
    end
  endtask

  task automatic test_wrap;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    vectors++;
    if ({inst_addr, ifid_pc4, ifid_valid, ifid_inst} !== {32'h0, 32'h0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL pc_wrap: pc=%h pc4=%h v=%b inst=%h, expected 0 0 1 0",
               inst_addr, ifid_pc4, ifid_valid, ifid_inst);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0041, 32'h0800_0009);
    vectors++;
    if ({inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt} !== {32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_during_redirect: pc=%h v=%b inst=%h pc4=%h err=%b cnt=%0d, expected all zero",
               inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt);
    end
  endtask

  task automatic test_random;
    logic [31:0] ins;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if (($urandom % 4) == 0) ins = {6'b000010, ins[25:0]};
      if (($urandom % 10) == 0) ins = 32'h0;
      drive(($urandom % 40) == 0, ($urandom % 5) == 0, ($urandom % 8) == 0, $urandom, ins);
      vectors++;
      if ({inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt} !== {m_pc, m_valid, m_inst, m_pc4, m_err, m_cnt}) begin
        miscompares++;
        $display("FAIL random[%0d]: got pc=%h v=%b inst=%h pc4=%h err=%b cnt=%0d, model pc=%h v=%b inst=%h pc4=%h err=%b cnt=%0d",
                 i, inst_addr, ifid_valid, ifid_inst, ifid_pc4, addr_err, fetch_cnt,
                 m_pc, m_valid, m_inst, m_pc4, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0; inst = 32'h0;
    m_pc = 32'h0; m_valid = 1'b0; m_inst = 32'h0; m_pc4 = 32'h0; m_err = 1'b0; m_cnt = 32'h0;
    test_reset();
    test_jump();
    test_stall();
    test_redirect_stall();
    test_addr_err();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
